// File: rtl/inference_sequencer.sv
// inference_sequencer
// Top-level controller for one classification pass. Launches each layer
// engine in turn, packs the serial output-neuron stream of the final layer
// into a flat vector, hands that vector to the argmax unit and holds the
// resulting digit on a valid/ready result interface. A watchdog aborts the
// pass when any wait state sees no progress for TIMEOUT cycles.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               begin a pass (only honoured in IDLE)
//   busy                high while a pass is in flight (not in IDLE/DONE)
//   layer_start         one-cycle launch pulse for layer layer_sel
//   layer_sel           index of the active layer
//   layer_done          completion pulse from the active layer engine
//   neuron_valid/data   final-layer neuron stream, index 0 first
//   am_in_valid         one-cycle strobe to the argmax unit
//   am_neuron_outputs   packed neurons, slot i at [i*OUT_W +: OUT_W]
//   am_prediction       argmax result, qualified by am_out_valid
//   prediction          latched classification
//   result_valid        prediction available, cleared on result_ready
//   timeout_err         sticky abort flag, cleared by the next start
module inference_sequencer #(
    parameter int NUM_LAYERS  = 2,
    parameter int NUM_CLASSES = 10,
    parameter int OUT_W       = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         layer_start,
    output logic [2:0]                   layer_sel,
    input  logic                         layer_done,
    input  logic                         neuron_valid,
    input  logic [OUT_W-1:0]             neuron_data,
    output logic                         am_in_valid,
    output logic [NUM_CLASSES*OUT_W-1:0] am_neuron_outputs,
    input  logic [3:0]                   am_prediction,
    input  logic                         am_out_valid,
    output logic [3:0]                   prediction,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         timeout_err
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [2:0]       LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CLASSES - 1);
    localparam logic [9:0]       WD_LIMIT   = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LAYER,
        COLLECT,
        ARGMAX,
        WAIT_AM,
        DONE
    } state_t;

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [9:0]                   wd;
    logic [NUM_CLASSES*OUT_W-1:0] buffer;

    // The packed vector is the buffer itself, so it stays stable from ARGMAX
    // until the next accepted start clears it.
    assign am_neuron_outputs = buffer;

    // Single sequencing process. layer_start and am_in_valid default low each
    // cycle and are raised only on the transition into LAUNCH / ARGMAX, which
    // makes them exact one-cycle pulses aligned with those states. The
    // watchdog is cleared on every state change and every accepted event; the
    // abort fires on the cycle whose increment would reach TIMEOUT, so a
    // stalled wait state lasts exactly TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wd           <= '0;
            buffer       <= '0;
            busy         <= 1'b0;
            layer_start  <= 1'b0;
            layer_sel    <= '0;
            am_in_valid  <= 1'b0;
            prediction   <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            layer_start <= 1'b0;
            am_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout_err <= 1'b0;
                        buffer      <= '0;
                        layer_sel   <= '0;
                        idx         <= '0;
                        wd          <= '0;
                        busy        <= 1'b1;
                        layer_start <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd    <= '0;
                    state <= WAIT_LAYER;
                end
                WAIT_LAYER: begin
                    if (layer_done) begin
                        wd <= '0;
                        if (layer_sel < LAST_LAYER) begin
                            layer_sel   <= layer_sel + 3'd1;
                            layer_start <= 1'b1;
                            state       <= LAUNCH;
                        end else begin
                            idx   <= '0;
                            state <= COLLECT;
                        end
                    end else if (wd == WD_LIMIT) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                COLLECT: begin
                    if (neuron_valid) begin
                        wd <= '0;
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                buffer[i*OUT_W +: OUT_W] <= neuron_data;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            am_in_valid <= 1'b1;
                            state       <= ARGMAX;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (wd == WD_LIMIT) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                ARGMAX: begin
                    wd    <= '0;
                    state <= WAIT_AM;
                end
                WAIT_AM: begin
                    if (am_out_valid) begin
                        wd           <= '0;
                        prediction   <= am_prediction;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (wd == WD_LIMIT) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer
// Directed-plus-random bench for inference_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge. The layer engines and argmax
// unit are modelled procedurally; the expected packed vector and prediction
// come from the neuron list itself (slot packing and lowest-index argmax).
module tb_inference_sequencer;

    localparam int NL = 2;
    localparam int NC = 10;
    localparam int OW = 4;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            layer_start;
    logic [2:0]      layer_sel;
    logic            layer_done;
    logic            neuron_valid;
    logic [OW-1:0]   neuron_data;
    logic            am_in_valid;
    logic [NC*OW-1:0] am_neuron_outputs;
    logic [3:0]      am_prediction;
    logic            am_out_valid;
    logic [3:0]      prediction;
    logic            result_valid;
    logic            result_ready;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit tieReady = 1'b0;
    logic [OW-1:0] stim [NC];

    inference_sequencer #(
        .NUM_LAYERS(NL), .NUM_CLASSES(NC), .OUT_W(OW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .layer_start(layer_start), .layer_sel(layer_sel),
        .layer_done(layer_done), .neuron_valid(neuron_valid),
        .neuron_data(neuron_data), .am_in_valid(am_in_valid),
        .am_neuron_outputs(am_neuron_outputs), .am_prediction(am_prediction),
        .am_out_valid(am_out_valid), .prediction(prediction),
        .result_valid(result_valid), .result_ready(result_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_layer_start"}, layer_start, 0);
        checkOutput({tag, "_layer_sel"}, layer_sel, 0);
        checkOutput({tag, "_am_in_valid"}, am_in_valid, 0);
        checkOutput({tag, "_vec"}, am_neuron_outputs, 0);
        checkOutput({tag, "_prediction"}, prediction, 0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic waitLayerStart(input int limit);
        int waited = 0;
        while (!layer_start && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wait_layer_start", layer_start, 1);
    endtask

    // Drive a start pulse and check that it was accepted.
    task automatic startPulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_err_clear", timeout_err, 0);
        checkOutput("start_buf_clear", am_neuron_outputs, 0);
    endtask

    // Engine model for all layers: layerDelay idle WAIT_LAYER cycles before
    // layer_done. With spurious set, a layer_done coincides with layer_start
    // and neuron_valid toggles while waiting; both must be ignored.
    task automatic runLayers(input int layerDelay, input bit spurious);
        for (int l = 0; l < NL; l++) begin
            waitLayerStart(50);
            checkOutput("layer_sel", layer_sel, l);
            if (spurious && layerDelay > 0) layer_done = 1'b1;
            @(negedge clk);
            layer_done = 1'b0;
            checkOutput("layer_start_pulse", layer_start, 0);
            for (int d = 0; d < layerDelay; d++) begin
                if (spurious) begin
                    neuron_valid = d[0];
                    neuron_data  = 4'($urandom);
                end
                @(negedge clk);
            end
            neuron_valid = 1'b0;
            layer_done   = 1'b1;
            @(negedge clk);
            layer_done = 1'b0;
        end
    endtask

    // One complete pass over the neurons in stim[].
    task automatic applyStimulus(input int layerDelay, input int gapMax, input bit spurious,
                                 input int holdCycles, input bit pokeStart, input bit checkLat);
        logic [NC*OW-1:0] expVec;
        int expPred;
        int startCyc;
        int gap;
        expVec  = '0;
        expPred = 0;
        for (int i = 0; i < NC; i++) begin
            expVec[i*OW +: OW] = stim[i];
            if (stim[i] > stim[expPred]) expPred = i;
        end

        startCyc = cyc;
        startPulse();
        runLayers(layerDelay, spurious);

        for (int i = 0; i < NC; i++) begin
            gap = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            repeat (gap) @(negedge clk);
            neuron_valid = 1'b1;
            neuron_data  = stim[i];
            @(negedge clk);
            neuron_valid = 1'b0;
        end

        checkOutput("am_in_valid", am_in_valid, 1);
        checkOutput("am_vec", am_neuron_outputs, expVec);
        @(negedge clk);
        checkOutput("am_in_pulse", am_in_valid, 0);
        am_out_valid  = 1'b1;
        am_prediction = 4'(expPred);
        @(negedge clk);
        am_out_valid  = 1'b0;
        am_prediction = 4'($urandom);

        checkOutput("result_valid", result_valid, 1);
        checkOutput("prediction", prediction, expPred);
        checkOutput("done_busy", busy, 0);
        if (checkLat) checkOutput("latency", cyc - startCyc, 17);

        for (int h = 0; h < holdCycles; h++) begin
            if (pokeStart && h == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("hold_valid", result_valid, 1);
            checkOutput("hold_prediction", prediction, expPred);
            checkOutput("hold_busy", busy, 0);
            checkOutput("hold_no_launch", layer_start, 0);
        end
        checkOutput("hold_vec", am_neuron_outputs, expVec);

        result_ready = 1'b1;
        @(negedge clk);
        if (!tieReady) result_ready = 1'b0;
        checkOutput("result_cleared", result_valid, 0);
        checkOutput("idle_busy", busy, 0);
    endtask

    task automatic randomStim();
        for (int i = 0; i < NC; i++) stim[i] = 4'($urandom);
    endtask

    // Layer 1 never completes: the watchdog must abort the pass.
    task automatic watchdogTest();
        int n = 0;
        bit sawResult = 1'b0;
        startPulse();
        waitLayerStart(50);
        @(negedge clk);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        waitLayerStart(50);
        while (!timeout_err && n < 1100) begin
            @(negedge clk);
            n++;
            if (result_valid) sawResult = 1'b1;
        end
        // TO cycles in WAIT_LAYER, plus the LAUNCH cycle before it.
        checkOutput("wd_cycles", n, TO + 1);
        checkOutput("wd_no_result", sawResult, 0);
        checkOutput("wd_err", timeout_err, 1);
        checkOutput("wd_busy", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("wd_sticky", timeout_err, 1);
        checkOutput("wd_idle_no_launch", layer_start, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; layer_done = 1'b0; neuron_valid = 1'b0;
        neuron_data = '0; am_prediction = '0; am_out_valid = 1'b0; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] nominal pass");
        stim = '{4'd1, 4'd3, 4'd2, 4'd9, 4'd0, 4'd4, 4'd9, 4'd1, 4'd0, 4'd2};
        applyStimulus(5, 0, 1'b0, 3, 1'b0, 1'b0);

        $display("[TB] gapped stream with spurious pulses");
        randomStim();
        applyStimulus(4, 10, 1'b1, 2, 1'b0, 1'b0);

        $display("[TB] backpressure");
        randomStim();
        applyStimulus(1, 0, 1'b0, 20, 1'b1, 1'b0);
        randomStim();
        applyStimulus(0, 0, 1'b0, 1, 1'b0, 1'b1);

        $display("[TB] watchdog");
        watchdogTest();
        randomStim();
        applyStimulus(2, 3, 1'b0, 1, 1'b0, 1'b0);

        $display("[TB] reset mid-collection");
        for (int i = 0; i < NC; i++) stim[i] = 4'($urandom_range(1, 15));
        startPulse();
        runLayers(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            neuron_valid = 1'b1;
            neuron_data  = stim[i];
            @(negedge clk);
        end
        neuron_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midreset");
        rst = 1'b0;
        @(negedge clk);
        randomStim();
        applyStimulus(0, 0, 1'b0, 1, 1'b0, 1'b1);

        $display("[TB] back-to-back passes");
        tieReady = 1'b1;
        result_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NC; i++) stim[i] = 4'($urandom_range(0, 14));
            stim[(p * 3 + 2) % NC] = 4'd15;
            applyStimulus(0, 0, 1'b0, 0, 1'b0, 1'b1);
        end
        tieReady = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);

        $display("[TB] random passes");
        for (int r = 0; r < 4; r++) begin
            randomStim();
            applyStimulus($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 4), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
